// File: rtl/dram_cmd_sched_pkg.sv
// Shared constants and FSM state type for the DRAM command scheduler.
// The command encodings match the DDR controller's native command port.
package dram_pkg;
  localparam int N_INIT = 4;
  localparam int LG_XID = 2;
  localparam logic [2:0] DDR_CMD_RD = 3'b001;
  localparam logic [2:0] DDR_CMD_WR = 3'b000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CMD   = 2'd1,
    WDATA = 2'd2
  } state_e;
endpackage

// File: rtl/dram_cmd_sched_if.sv
// Initiator request bus, DDR command/write-data port and read-tag FIFO push.
// slave = scheduler view, master = initiators/controller/FIFO view.
interface dram_cmd_sched_if #(
  parameter int N_INIT = dram_pkg::N_INIT,
  parameter int LG_XID = dram_pkg::LG_XID,
  parameter int TAG_W  = $clog2(N_INIT) + LG_XID
) ();
  logic [N_INIT-1:0]        req_valid;
  logic [N_INIT-1:0]        req_we;
  logic [N_INIT*23-1:0]     req_addr;
  logic [N_INIT*LG_XID-1:0] req_xid;
  logic [N_INIT*128-1:0]    req_wdata;
  logic [N_INIT*16-1:0]     req_wmask;
  logic [N_INIT-1:0]        req_ready;
  logic                     ddr_calib_done;
  logic [2:0]               ddr_cmd;
  logic                     ddr_cmd_en;
  logic [27:0]              ddr_addr;
  logic                     ddr_cmd_ready;
  logic [127:0]             ddr_wr_data;
  logic [15:0]              ddr_wr_data_mask;
  logic                     ddr_wr_data_en;
  logic                     ddr_wr_data_rdy;
  logic                     tag_push;
  logic [TAG_W-1:0]         tag_data;
  logic                     tag_full;

  modport slave (
    input  req_valid, req_we, req_addr, req_xid, req_wdata, req_wmask,
    input  ddr_calib_done, ddr_cmd_ready, ddr_wr_data_rdy, tag_full,
    output req_ready, ddr_cmd, ddr_cmd_en, ddr_addr,
    output ddr_wr_data, ddr_wr_data_mask, ddr_wr_data_en, tag_push, tag_data
  );

  modport master (
    output req_valid, req_we, req_addr, req_xid, req_wdata, req_wmask,
    output ddr_calib_done, ddr_cmd_ready, ddr_wr_data_rdy, tag_full,
    input  req_ready, ddr_cmd, ddr_cmd_en, ddr_addr,
    input  ddr_wr_data, ddr_wr_data_mask, ddr_wr_data_en, tag_push, tag_data
  );
endinterface

// File: rtl/dram_cmd_sched_rr_pick.sv
// Combinational round-robin picker: first eligible index after last_i, wrapping.
// last_i itself has the lowest priority.
module rr_pick #(
  parameter int N     = dram_pkg::N_INIT,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     elig_i,
  input  logic [IDX_W-1:0] last_i,
  output logic [N-1:0]     onehot_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);
  logic [IDX_W-1:0] cand;

  // Walk from lowest to highest priority so the nearest eligible index wins.
  always_comb begin
    idx_o = '0;
    any_o = 1'b0;
    cand  = '0;
    for (int i = N; i >= 1; i--) begin
      cand = IDX_W'((int'(last_i) + i) % N);
      if (elig_i[cand]) begin
        idx_o = cand;
        any_o = 1'b1;
      end
    end
    onehot_o        = '0;
    onehot_o[idx_o] = any_o;
  end
endmodule

// File: rtl/dram_cmd_sched.sv
// Arbitrates N_INIT initiators onto a single DDR command port, one request in flight.
// Reads push {initiator, xid} into the external return-tag FIFO on command accept.
module dram_cmd_sched #(
  parameter int N_INIT = dram_pkg::N_INIT,
  parameter int LG_XID = dram_pkg::LG_XID
) (
  input logic             clk,
  input logic             rst,
  dram_cmd_sched_if.slave bus
);
  import dram_pkg::*;

  localparam int IDX_W = $clog2(N_INIT);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   last_q, idx_q, win_idx;
  logic [N_INIT-1:0]  elig, win_oh;
  logic               win_any, grant;
  logic               we_q;
  logic [22:0]        addr_q;
  logic [LG_XID-1:0]  xid_q;
  logic [127:0]       wdata_q;
  logic [15:0]        wmask_q;

  // Reads need a tag FIFO slot; tag_full is only consulted here, at grant.
  assign elig  = bus.req_valid & (bus.req_we | {N_INIT{~bus.tag_full}});
  assign grant = (state_q == IDLE) && bus.ddr_calib_done && win_any && !rst;

  rr_pick #(.N(N_INIT), .IDX_W(IDX_W)) u_rr_pick (
    .elig_i   (elig),
    .last_i   (last_q),
    .onehot_o (win_oh),
    .idx_o    (win_idx),
    .any_o    (win_any)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant) state_d = CMD;
      CMD:     if (bus.ddr_cmd_ready) state_d = we_q ? WDATA : IDLE;
      WDATA:   if (bus.ddr_wr_data_rdy) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q  <= IDX_W'(N_INIT - 1);
      idx_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      xid_q   <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
    end else if (grant) begin
      last_q  <= win_idx;
      idx_q   <= win_idx;
      we_q    <= bus.req_we[win_idx];
      addr_q  <= bus.req_addr[int'(win_idx)*23 +: 23];
      xid_q   <= bus.req_xid[int'(win_idx)*LG_XID +: LG_XID];
      wdata_q <= bus.req_wdata[int'(win_idx)*128 +: 128];
      wmask_q <= bus.req_wmask[int'(win_idx)*16 +: 16];
    end
  end

  // Outputs are forced low while rst is high so an abandoned command never leaks out.
  always_comb begin
    bus.req_ready        = '0;
    bus.ddr_cmd          = '0;
    bus.ddr_cmd_en       = 1'b0;
    bus.ddr_addr         = '0;
    bus.ddr_wr_data      = '0;
    bus.ddr_wr_data_mask = '0;
    bus.ddr_wr_data_en   = 1'b0;
    bus.tag_push         = 1'b0;
    bus.tag_data         = '0;
    if (!rst) begin
      case (state_q)
        IDLE: bus.req_ready = grant ? win_oh : '0;
        CMD: begin
          bus.ddr_cmd_en = 1'b1;
          bus.ddr_cmd    = we_q ? DDR_CMD_WR : DDR_CMD_RD;
          bus.ddr_addr   = {1'b0, addr_q, 4'b0};
          if (bus.ddr_cmd_ready && !we_q) begin
            bus.tag_push = 1'b1;
            bus.tag_data = {idx_q, xid_q};
          end
        end
        WDATA: begin
          bus.ddr_wr_data_en   = 1'b1;
          bus.ddr_wr_data      = wdata_q;
          bus.ddr_wr_data_mask = wmask_q;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: doc/dram_cmd_sched.md
DRAM_CMD_SCHED -- requirements
Module: dram_cmd_sched

Interface
REQ-001 Parameter: N_INIT, 4, number of initiators (initiator index = tag MSBs).
REQ-002 Parameter: LG_XID, 2, transaction-ID width per initiator.
REQ-003 Port: clk  input  1  single clock; all logic on posedge.
REQ-004 Port: rst  input  1  synchronous, active-high reset.
REQ-005 Port: req_valid  input  N_INIT  per-initiator request valid; held until accepted.
REQ-006 Port: req_we  input  N_INIT  1=write, 0=read.
REQ-007 Port: req_addr  input  N_INIT*23  16-byte line address bits [26:4] per initiator.
REQ-008 Port: req_xid  input  N_INIT*LG_XID  transaction ID per initiator.
REQ-009 Port: req_wdata  input  N_INIT*128  write data per initiator.
REQ-010 Port: req_wmask  input  N_INIT*16  byte mask per initiator, 1 = byte not written.
REQ-011 Port: req_ready  output  N_INIT  one-cycle accept pulse to the granted initiator.
REQ-012 Port: ddr_calib_done  input  1  DDR controller calibrated.
REQ-013 Port: ddr_cmd  output  3  3'b001 read, 3'b000 write.
REQ-014 Port: ddr_cmd_en  output  1  command valid.
REQ-015 Port: ddr_addr  output  28  {1'b0, addr[26:4], 4'b0}.
REQ-016 Port: ddr_cmd_ready  input  1  controller accepts command when high with ddr_cmd_en.
REQ-017 Port: ddr_wr_data / ddr_wr_data_mask / ddr_wr_data_en  output  128/16/1  write beat.
REQ-018 Port: ddr_wr_data_rdy  input  1  controller accepts write beat when high with ddr_wr_data_en.
REQ-019 Port: tag_push / tag_data  output  1/(log2(N_INIT)+LG_XID)  push {init,xid} into the external read-return tag FIFO.
REQ-020 Port: tag_full  input  1  external tag FIFO full.

Function
REQ-021 FSM states IDLE, CMD, WDATA; exactly one request in flight inside the block.
REQ-022 Eligible initiator: req_valid=1 and (req_we=1 or tag_full=0).
REQ-023 IDLE: if ddr_calib_done=1 and any eligible initiator, grant by round-robin starting at last_grant+1 (mod N_INIT); pulse req_ready[winner] the same cycle; latch we/addr/xid/wdata/wmask/index; update last_grant; go CMD.
REQ-024 IDLE with ddr_calib_done=0 or no eligible initiator: req_ready=0, no state change.
REQ-025 CMD: ddr_cmd_en=1 with latched command/address, held stable until ddr_cmd_ready=1.
REQ-026 CMD accept of a read: tag_push=1 for exactly that cycle with latched {index,xid}; next state IDLE.
REQ-027 CMD accept of a write: next state WDATA; no tag push.
REQ-028 WDATA: ddr_wr_data_en=1 with latched data/mask, held until ddr_wr_data_rdy=1; then IDLE.
REQ-029 ddr_cmd_en, ddr_wr_data_en and tag_push are 0 outside their states; ddr_wr_data/mask drive 0 outside WDATA.
REQ-030 Minimum spacing: read one command per 2 cycles, write one per 3 cycles.
REQ-031 tag_full is sampled only at grant; block never pushes when the FIFO is full (it is the only pusher).
REQ-032 ddr_calib_done falling mid-transaction does not abort it; it gates only new grants.

Reset
REQ-033 rst=1 forces IDLE, last_grant=N_INIT-1 (initiator 0 first), all outputs 0, latched request cleared.
REQ-034 Reset during CMD/WDATA abandons the transaction: no tag_push, no further ddr_cmd_en/ddr_wr_data_en.

Structure
REQ-035 Package dram_pkg holds N_INIT, LG_XID, DDR_CMD_RD, DDR_CMD_WR, and the FSM state enum.
REQ-036 Round-robin selection lives in sub-module rr_pick (eligible vector + last_grant in, one-hot/index winner out, combinational).

Verification
REQ-037 Read init0 addr 23'h000123 xid 2, cmd_ready=1 -> ddr_addr 28'h0001230, ddr_cmd 001, tag_push with tag_data 4'b0010 one cycle after grant.
REQ-038 All four inits continuously requesting reads -> grants in order 0,1,2,3,0, one every 2 cycles.
REQ-039 Write init2 mask 16'h00FF, cmd_ready low 3 cycles, wr_data_rdy low 2 cycles -> ddr_cmd_en high 4 cycles, ddr_wr_data_en high 3 cycles, mask 16'h00FF, no tag_push.
REQ-040 tag_full=1 with init0 read and init1 write valid -> init1 granted; init0 granted only after tag_full=0.
REQ-041 ddr_calib_done=0 with init3 valid -> no req_ready/ddr_cmd_en; grant on first cycle after calib_done=1.
REQ-042 rst asserted while in CMD -> next cycle ddr_cmd_en=0, no tag_push, next grant goes to init0.
